// File: rtl/spi_arb_pkg.sv
// Shared types and field widths for the SPI request arbiter.
// Frame field widths and the arbiter FSM state encoding.
package spi_arb_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI,
        COOL,
        DRAIN
    } state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx, any out.
module spi_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        int            j;
        logic [IW-1:0] sel;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        sel = '0;
        // k runs 1..NUM_REQ so ptr itself is checked last
        for (int k = 1; k <= NUM_REQ; k++) begin
            j   = (int'(ptr) + k) % NUM_REQ;
            sel = IW'(j);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin scheduler sharing one spi_master among NUM_REQ requesters.
// Ports: clk, rst_n; req/req_cmd/req_addr/req_wdata in; done/rdata/err/busy/
// gnt_id out; m_en/m_cmd/m_addr/m_wdata to master; m_cs/m_rdata from master.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_cmd,
    input  logic [NUM_REQ*24-1:0]      req_addr,
    input  logic [NUM_REQ*32-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         done,
    output logic [31:0]                rdata,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       m_en,
    output logic [7:0]                 m_cmd,
    output logic [23:0]                m_addr,
    output logic [31:0]                m_wdata,
    input  logic                       m_cs,
    input  logic [31:0]                m_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    state_t              state, state_n;
    logic [IW-1:0]       ptr, ptr_n, gnt_n, pick_idx;
    logic [NUM_REQ-1:0]  pick_gnt, done_n;
    logic                pick_any, m_en_n, busy_n;
    logic [CMD_W-1:0]    sel_cmd, cmd_n;
    logic [ADDR_W-1:0]   sel_addr, addr_n;
    logic [DATA_W-1:0]   sel_wdata, wdata_n, rdata_n;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          err_q, err_n;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_cmd   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_cmd   = req_cmd[i*CMD_W +: CMD_W];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt_id;
        m_en_n  = 1'b0;
        busy_n  = busy;
        done_n  = done;
        rdata_n = rdata;
        cmd_n   = m_cmd;
        addr_n  = m_addr;
        wdata_n = m_wdata;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_n   = pick_idx;
                    cmd_n   = sel_cmd;
                    addr_n  = sel_addr;
                    wdata_n = sel_wdata;
                    m_en_n  = 1'b1;
                    busy_n  = 1'b1;
                    state_n = WAIT_LO;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            WAIT_LO: begin
                if (!m_cs) state_n = WAIT_HI;
            end
            WAIT_HI: begin
                // master updates cs and read word on the same edge
                if (m_cs) begin
                    rdata_n = m_rdata;
                    done_n  = NUM_REQ'(1) << gnt_id;
                    ptr_n   = gnt_id;
                    state_n = COOL;
                end
            end
            COOL: begin
                done_n  = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                err_n   = 1'b0;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            DRAIN: begin
                done_n = '0;
                err_n  = 1'b0;
                if (m_cs) state_n = COOL;
            end
`endif
            default: state_n = IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        // normal completion wins over a same-cycle timeout
        if ((state == WAIT_LO || state == WAIT_HI) && state_n != COOL) begin
            if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                done_n  = NUM_REQ'(1) << gnt_id;
                err_n   = 1'b1;
                rdata_n = '0;
                ptr_n   = gnt_id;
                state_n = DRAIN;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IW'(NUM_REQ - 1);
            gnt_id  <= '0;
            m_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= '0;
            rdata   <= '0;
            m_cmd   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt_id  <= gnt_n;
            m_en    <= m_en_n;
            busy    <= busy_n;
            done    <= done_n;
            rdata   <= rdata_n;
            m_cmd   <= cmd_n;
            m_addr  <= addr_n;
            m_wdata <= wdata_n;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt     <= cnt_n;
            err_q   <= err_n;
`endif
        end
    end

endmodule
